vreg_loader: RTL and testbench

VREG_LOADER -- requirements
Module: vreg_loader

---
 rtl/vreg_loader.sv | 180 ++++++++++++++++++
 tb/tb_vreg_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_loader.sv
// rtl/vreg_loader.sv - assembles up to eight 32-bit beats into a 256-bit register write
// Optional READ readback port enabled by VREG_LOADER_READBACK_EN.
module vreg_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [9:0]   cmd_payload_function_id,
    input  logic [31:0]  cmd_payload_inputs_0,
    input  logic [31:0]  cmd_payload_inputs_1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_payload_outputs_0,
    output logic [4:0]   wb_sel,
    output logic [255:0] wb_data,
    output logic         wb_load
`ifdef VREG_LOADER_READBACK_EN
    ,
    output logic [4:0]   rd_sel,
    input  logic [255:0] rd_value
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [2:0] OP_START = 3'd0;
    localparam logic [2:0] OP_DATA  = 3'd1;
    localparam logic [2:0] OP_ABORT = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;

    state_t         state;
    state_t         state_n;
    logic [4:0]     dest;
    logic [3:0]     beats;
    logic [3:0]     cnt;
    logic [255:0]   vec;

    logic           accept;
    logic [2:0]     op;
    logic           do_start;
    logic           do_data;
    logic           do_abort;
    logic           do_read;
    logic           err;
    logic [3:0]     cnt_inc;
    logic [3:0]     cnt_after;
    logic [3:0]     beats_in;
    logic [3:0]     beats_eff;
    logic [31:0]    read_word;
    logic [31:0]    rsp_next;

    logic unused_bits;
    assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[31:4]};

    assign op        = cmd_payload_function_id[2:0];
    assign accept    = cmd_valid && cmd_ready;
    assign cnt_inc   = cnt + 4'd1;
    assign beats_in  = cmd_payload_inputs_1[3:0];
    assign beats_eff = (beats_in == 4'd0 || beats_in > 4'd8) ? 4'd8 : beats_in;

    // A stalled response blocks new commands; a response being taken does not.
    assign cmd_ready = !reset && (state != COMMIT) && !(rsp_valid && !rsp_ready);

    assign wb_load = (state == COMMIT) && !reset;
    assign wb_sel  = wb_load ? dest : 5'd0;
    assign wb_data = wb_load ? vec : 256'd0;

`ifdef VREG_LOADER_READBACK_EN
    assign rd_sel    = cmd_payload_inputs_0[4:0];
    assign read_word = rd_value[{cmd_payload_inputs_1[2:0], 5'd0} +: 32];
`else
    assign read_word = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        do_start = 1'b0;
        do_data  = 1'b0;
        do_abort = 1'b0;
        do_read  = 1'b0;
        err      = 1'b0;
        if (accept) begin
            case (op)
                OP_START: begin
                    if (state == IDLE) begin
                        do_start = 1'b1;
                        state_n  = FILL;
                    end else begin
                        err = 1'b1;
                    end
                end
                OP_DATA: begin
                    if (state == FILL) begin
                        do_data = 1'b1;
                        if (cnt_inc == beats) begin
                            state_n = COMMIT;
                        end
                    end else begin
                        err = 1'b1;
                    end
                end
                OP_ABORT: begin
                    do_abort = 1'b1;
                    state_n  = IDLE;
                end
`ifdef VREG_LOADER_READBACK_EN
                OP_READ: begin
                    if (state == IDLE) begin
                        do_read = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
`endif
                default: err = 1'b1;
            endcase
        end
        if (state == COMMIT) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        cnt_after = cnt;
        if (do_start || do_abort) begin
            cnt_after = 4'd0;
        end else if (do_data) begin
            cnt_after = cnt_inc;
        end
        rsp_next = {16'd0, 4'd0, cnt_after, 6'd0, err, (state_n != IDLE)};
        if (do_read) begin
            rsp_next = read_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest                  <= 5'd0;
            beats                 <= 4'd0;
            cnt                   <= 4'd0;
            vec                   <= 256'd0;
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= 32'd0;
        end else begin
            if (do_start) begin
                dest  <= cmd_payload_inputs_0[4:0];
                beats <= beats_eff;
                cnt   <= 4'd0;
                vec   <= 256'd0;
            end else if (do_data) begin
                vec[{cnt[2:0], 5'd0} +: 32] <= cmd_payload_inputs_0;
                cnt                         <= cnt_inc;
            end else if (do_abort || state == COMMIT) begin
                // Leave IDLE with a clean vector so a short fill zero-pads.
                vec <= 256'd0;
                cnt <= 4'd0;
            end

            if (accept) begin
                rsp_valid             <= 1'b1;
                rsp_payload_outputs_0 <= rsp_next;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vreg_loader.sv
// tb/tb_vreg_loader.sv - directed plus random checks of vreg_loader against a behavioural model
// Honours VREG_LOADER_READBACK_EN to match the design build.
module tb_vreg_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [9:0]   cmd_payload_function_id = '0;
    logic [31:0]  cmd_payload_inputs_0 = '0;
    logic [31:0]  cmd_payload_inputs_1 = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [31:0]  rsp_payload_outputs_0;
    logic [4:0]   wb_sel;
    logic [255:0] wb_data;
    logic         wb_load;
`ifdef VREG_LOADER_READBACK_EN
    logic [4:0]   rd_sel;
    logic [255:0] rd_value = '0;
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    vreg_loader dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .wb_sel                  (wb_sel),
        .wb_data                 (wb_data),
        .wb_load                 (wb_load)
`ifdef VREG_LOADER_READBACK_EN
        ,
        .rd_sel                  (rd_sel),
        .rd_value                (rd_value)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the loader.
    bit           m_filling;
    int           m_dest;
    int           m_beats;
    int           m_cnt;
    logic [31:0]  m_words [8];
    logic [4:0]   exp_sel [$];
    logic [255:0] exp_data [$];
    logic [4:0]   got_sel [$];
    logic [255:0] got_data [$];
    logic [255:0] rd_image = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_load === 1'b1) begin
            got_sel.push_back(wb_sel);
            got_data.push_back(wb_data);
        end else begin
            chk("wb_idle_zero", {wb_load, wb_sel, wb_data}, '0);
        end
    end

    task automatic model_clear();
        m_filling = 1'b0;
        m_cnt     = 0;
        for (int i = 0; i < 8; i++) m_words[i] = 32'd0;
    endtask

    task automatic model_cmd(input int op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] exp);
        logic [255:0] v;
        int nb;
        exp = 32'd0;
        if (op == 0 && !m_filling) begin
            model_clear();
            m_dest    = int'(a % 32);
            nb        = int'(b % 16);
            m_beats   = (nb == 0 || nb > 8) ? 8 : nb;
            m_filling = 1'b1;
            exp       = 32'd1;
        end else if (op == 1 && m_filling) begin
            m_words[m_cnt] = a;
            m_cnt++;
            exp = 32'(m_cnt * 256 + 1);
            if (m_cnt == m_beats) begin
                for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_words[i];
                exp_sel.push_back(5'(m_dest));
                exp_data.push_back(v);
                model_clear();
            end
        end else if (op == 2) begin
            model_clear();
            exp = 32'd0;
        end else if (op == 3 && READBACK && !m_filling) begin
            exp = rd_image[(b % 8) * 32 +: 32];
        end else begin
            exp = 32'(m_cnt * 256 + 2 + (m_filling ? 1 : 0));
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, got_sel.size(), exp_sel.size());
        while (got_sel.size() > 0 && exp_sel.size() > 0) begin
            chk({tag, "_sel"}, got_sel.pop_front(), exp_sel.pop_front());
            chk({tag, "_data"}, got_data.pop_front(), exp_data.pop_front());
        end
        got_sel.delete(); got_data.delete(); exp_sel.delete(); exp_data.delete();
    endtask

    task automatic send(input int op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output int waited);
        logic [31:0] exp;
        logic [31:0] got;
        cmd_valid = 1'b1;
        cmd_payload_function_id = {7'($urandom), 3'(op)};
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        rsp_ready = 1'b1;
        waited = 0;
        #1;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $error("FAIL cmd_accept_timeout observed=0 expected=1");
            cmd_valid = 1'b0;
            return;
        end
        model_cmd(op, a, b, exp);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_payload", rsp_payload_outputs_0, exp);
        got = rsp_payload_outputs_0;
        rsp_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_payload", rsp_payload_outputs_0, got);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_cmd_ready", cmd_ready, 1'b0);
            chk("rst_rsp", {rsp_valid, rsp_payload_outputs_0}, '0);
            chk("rst_wb", {wb_load, wb_sel, wb_data}, '0);
        end
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        model_clear();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int w;
        int r;
        int op;
        model_clear();
        for (int i = 0; i < 8; i++) rd_image[i*32 +: 32] = $urandom;
        rd_image[3*32 +: 32] = 32'hDEADBEEF;
`ifdef VREG_LOADER_READBACK_EN
        rd_value = rd_image;
`endif
        do_reset(2);

        // Full eight-beat load.
        send(0, 32'd5, 32'd8, 0, w);
        for (int i = 0; i < 8; i++) send(1, 32'(i), 32'd0, 0, w);
        idle(3);
        check_writes("full_load");

        // Short load zero-pads the upper words.
        send(0, 32'd2, 32'd3, 0, w);
        send(1, 32'hA, 32'd0, 0, w);
        send(1, 32'hB, 32'd0, 0, w);
        send(1, 32'hC, 32'd0, 0, w);
        idle(3);
        check_writes("short_load");

        // Rejections.
        send(1, 32'h1234, 32'd0, 0, w);
        send(0, 32'd9, 32'd4, 0, w);
        send(1, 32'h55, 32'd0, 0, w);
        send(0, 32'd3, 32'd2, 0, w);
        send(5, 32'd0, 32'd0, 0, w);
        send(2, 32'd0, 32'd0, 0, w);

        // Abort after two beats, then reset mid-fill with a stalled response.
        send(0, 32'd11, 32'd6, 0, w);
        send(1, 32'h1, 32'd0, 0, w);
        send(1, 32'h2, 32'd0, 0, w);
        send(2, 32'd0, 32'd0, 0, w);
        send(0, 32'd12, 32'd6, 0, w);
        send(1, 32'h3, 32'd0, 1, w);
        do_reset(2);
        idle(2);
        check_writes("abort_reset");

        // Back-pressure, then a command presented in the release cycle.
        send(0, 32'd7, 32'd2, 4, w);
        send(1, 32'h77, 32'd0, 0, w);
        chk("release_accept_wait", w, 0);
        send(1, 32'h88, 32'd0, 0, w);
        idle(3);
        check_writes("stall_load");

        // Readback (rejected when the feature is built out).
        cmd_payload_inputs_0 = 32'd7;
        #1;
`ifdef VREG_LOADER_READBACK_EN
        chk("rd_sel", rd_sel, 5'd7);
`endif
        send(3, 32'd7, 32'd3, 0, w);
        send(0, 32'd1, 32'd0, 0, w);
        send(3, 32'd7, 32'd3, 0, w);
        send(2, 32'd0, 32'd0, 0, w);

        // Random command mix.
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (m_filling) op = (r < 7) ? 1 : (r == 7) ? 0 : (r == 8) ? 2 : $urandom_range(3, 7);
            else op = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : $urandom_range(4, 7);
            send(op, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, w);
        end
        send(2, 32'd0, 32'd0, 0, w);
        idle(3);
        check_writes("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
